sdram_wb_arbiter: RTL and testbench

Two-master Wishbone (pipelined) arbiter that sits directly upstream of `sdram16_controller`. It multiplexes a CPU-side master and a DMA/video-side master onto the single controller slave port. A grant is held for the whole Wishbone cycle (`cyc` high), so the controller's 8-beat burst acknowledges are never split between masters.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/if_wb.sv | 25 ++
 rtl/wb_arb_pick.sv | 28 ++
 rtl/sdram_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of sdram16_controller.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        case (s)
            S_GNT0:  return GNT_M0;
            S_GNT1:  return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle; dat_i is write data toward the slave, dat_o is read data back.
interface if_wb #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_i;
    logic [DW-1:0]   dat_o;
    logic            ack;
    logic            stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_i,
        input  dat_o, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for the arbiter; sel_o=0 picks m0, sel_o=1 picks m1.
// SDRAM_ARB_RR_EN selects round-robin on contention; otherwise m0 has fixed priority.
module wb_arb_pick (
    input  logic req0_i,
    input  logic req1_i,
`ifdef SDRAM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic valid_o,
    output logic sel_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid_o = req0_i | req1_i;
        sel_o   = 1'b0;
        if (req0_i && req1_i) begin
`ifdef SDRAM_ARB_RR_EN
            sel_o = ~last_i;
`else
            sel_o = 1'b0;
`endif
        end else if (req1_i) begin
            sel_o = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter for sdram16_controller; a grant is held for the whole cyc.
// Build option: SDRAM_ARB_RR_EN enables round-robin contention, default is m0 fixed priority.
module sdram_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       out,
    output logic [1:0] grant_o
);

    localparam int SW = DW / 8;

    arb_state_t state_q;
    arb_state_t state_d;
    logic       pick_valid;
    logic       pick_sel;

`ifdef SDRAM_ARB_RR_EN
    logic last_q;
    logic last_d;
`endif

    wb_arb_pick u_pick (
        .req0_i (m0.cyc),
        .req1_i (m1.cyc),
`ifdef SDRAM_ARB_RR_EN
        .last_i (last_q),
`endif
        .valid_o(pick_valid),
        .sel_o  (pick_sel)
    );

    // Grant states only ever return to idle, so the controller always sees a low-cyc gap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = pick_sel ? S_GNT1 : S_GNT0;
                end
            end
            S_GNT0: begin
                if (!m0.cyc) begin
                    state_d = S_IDLE;
                end
            end
            S_GNT1: begin
                if (!m1.cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    // Reset value 1 lets m0 win the first contention.
    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && pick_valid) begin
            last_d = pick_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    logic          fwd_cyc;
    logic          fwd_stb;
    logic          fwd_we;
    logic [AW-1:0] fwd_adr;
    logic [SW-1:0] fwd_sel;
    logic [DW-1:0] fwd_dat;
    logic [DW-1:0] ret_dat;

    always_comb begin
        fwd_cyc = 1'b0;
        fwd_stb = 1'b0;
        fwd_we  = 1'b0;
        fwd_adr = '0;
        fwd_sel = '0;
        fwd_dat = '0;
        unique case (state_q)
            S_GNT0: begin
                fwd_cyc = m0.cyc;
                fwd_stb = m0.stb;
                fwd_we  = m0.we;
                fwd_adr = m0.adr;
                fwd_sel = m0.sel;
                fwd_dat = m0.dat_i;
            end
            S_GNT1: begin
                fwd_cyc = m1.cyc;
                fwd_stb = m1.stb;
                fwd_we  = m1.we;
                fwd_adr = m1.adr;
                fwd_sel = m1.sel;
                fwd_dat = m1.dat_i;
            end
            default: ;
        endcase
    end

    assign out.cyc   = fwd_cyc;
    assign out.stb   = fwd_stb;
    assign out.we    = fwd_we;
    assign out.adr   = fwd_adr;
    assign out.sel   = fwd_sel;
    assign out.dat_i = fwd_dat;
    assign ret_dat   = out.dat_o;

    // A master that is not granted sees a stalled, silent bus; stray acks go nowhere.
    always_comb begin
        m0.ack   = 1'b0;
        m0.stall = 1'b1;
        m0.dat_o = '0;
        m1.ack   = 1'b0;
        m1.stall = 1'b1;
        m1.dat_o = '0;
        unique case (state_q)
            S_GNT0: begin
                m0.ack   = out.ack;
                m0.stall = out.stall;
                m0.dat_o = ret_dat;
            end
            S_GNT1: begin
                m1.ack   = out.ack;
                m1.stall = out.stall;
                m1.dat_o = ret_dat;
            end
            default: ;
        endcase
    end

    assign grant_o = state_to_grant(state_q);

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter with an 8-beat burst slave model and a grant reference model.
module tb_sdram_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] grant_o;
    int         vectors     = 0;
    int         miscompares = 0;
    int         exp_gnt     = 0;   // 0 idle, 1 m0 granted, 2 m1 granted
    bit         exp_last    = 1'b1;

    if_wb #(.AW(AW), .DW(DW)) m0_bus ();
    if_wb #(.AW(AW), .DW(DW)) m1_bus ();
    if_wb #(.AW(AW), .DW(DW)) out_bus ();

    sdram_wb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .m0     (m0_bus),
        .m1     (m1_bus),
        .out    (out_bus),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    // Controller stand-in: accepts one request when idle, then acks 8 beats while stalling.
    logic          busy;
    logic [2:0]    beat;
    logic [DW-1:0] base;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic [SW-1:0] wr_sel;
    logic          wr_we;

    always @(posedge clk_i) begin
        if (rst_i) begin
            busy <= 1'b0;
            beat <= 3'd0;
        end else if (!busy) begin
            if (out_bus.cyc && out_bus.stb) begin
                busy   <= 1'b1;
                beat   <= 3'd0;
                base   <= DW'(out_bus.adr);
                wr_adr <= out_bus.adr;
                wr_dat <= out_bus.dat_i;
                wr_sel <= out_bus.sel;
                wr_we  <= out_bus.we;
            end
        end else begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) busy <= 1'b0;
        end
    end

    assign out_bus.ack   = busy;
    assign out_bus.stall = busy;
    assign out_bus.dat_o = busy ? base + DW'(beat) : '0;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    // Grant reference model, advanced on every rising edge from the arbitration rules.
    task automatic step();
        @(posedge clk_i);
        if (rst_i) begin
            exp_gnt  = 0;
            exp_last = 1'b1;
        end else begin
            case (exp_gnt)
                0: begin
                    if (m0_bus.cyc && m1_bus.cyc) begin
`ifdef SDRAM_ARB_RR_EN
                        exp_gnt = exp_last ? 1 : 2;
`else
                        exp_gnt = 1;
`endif
                    end else if (m0_bus.cyc) begin
                        exp_gnt = 1;
                    end else if (m1_bus.cyc) begin
                        exp_gnt = 2;
                    end
                    if (exp_gnt != 0) exp_last = (exp_gnt == 2);
                end
                1: if (!m0_bus.cyc) exp_gnt = 0;
                2: if (!m1_bus.cyc) exp_gnt = 0;
                default: exp_gnt = 0;
            endcase
        end
        @(negedge clk_i);
    endtask

    function automatic logic [1:0] model_vec();
        return (exp_gnt == 1) ? 2'b01 : (exp_gnt == 2) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] gvec(input int m);
        return (m == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic get_stall(input int m);
        return (m == 0) ? m0_bus.stall : m1_bus.stall;
    endfunction

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_bus.ack : m1_bus.ack;
    endfunction

    function automatic logic [DW-1:0] get_dat(input int m);
        return (m == 0) ? m0_bus.dat_o : m1_bus.dat_o;
    endfunction

    function automatic logic [AW-1:0] get_adr(input int m);
        return (m == 0) ? m0_bus.adr : m1_bus.adr;
    endfunction

    task automatic set_cyc(input int m, input logic v);
        if (m == 0) m0_bus.cyc = v; else m1_bus.cyc = v;
    endtask

    task automatic set_stb(input int m, input logic v);
        if (m == 0) m0_bus.stb = v; else m1_bus.stb = v;
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        if (m == 0) begin
            m0_bus.we = we; m0_bus.adr = adr; m0_bus.dat_i = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.we = we; m1_bus.adr = adr; m1_bus.dat_i = dat; m1_bus.sel = sel;
        end
    endtask

    task automatic idle_masters();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m0_bus.adr = '0; m0_bus.sel = '0; m0_bus.dat_i = '0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = '0; m1_bus.sel = '0; m1_bus.dat_i = '0;
        repeat (10) step();
    endtask

    task automatic pulse_reset(input int n);
        rst_i = 1'b1;
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    // Issues one request from master m (cyc already high) and counts what comes back.
    task automatic do_burst(input int m, output int acks_m, output int acks_o, output int route_err);
        logic accepted;
        logic take;
        acks_m    = 0;
        acks_o    = 0;
        route_err = 0;
        accepted  = 1'b0;
        set_stb(m, 1'b1);
        for (int n = 0; n < 40 && acks_m < 8; n++) begin
            take = !accepted && !get_stall(m);
            step();
            if (take) begin
                accepted = 1'b1;
                set_stb(m, 1'b0);
            end
            if (get_ack(m) === 1'b1) begin
                if (get_dat(m) !== DW'(get_adr(m)) + DW'(acks_m)) route_err++;
                acks_m++;
            end
            if (get_ack(1 - m) === 1'b1) acks_o++;
            if (get_stall(1 - m) !== 1'b1 || get_dat(1 - m) !== '0) route_err++;
            if (grant_o !== gvec(m)) route_err++;
        end
    endtask

    task automatic test_reset();
        int a, o, r;
        rst_i = 1'b1;
        set_req(0, 1'b0, 32'h0000_0400, '0, 4'hF);
        m0_bus.cyc = 1'b1;
        m0_bus.stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (grant_o !== 2'b00 || out_bus.cyc !== 1'b0 || out_bus.stb !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle: got grant=%b cyc=%b stb=%b, expected 00 0 0",
                         grant_o, out_bus.cyc, out_bus.stb);
            end
            vectors++;
            if (m0_bus.stall !== 1'b1 || m1_bus.stall !== 1'b1 || m0_bus.ack !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_stall: got m0.stall=%b m1.stall=%b m0.ack=%b, expected 1 1 0",
                         m0_bus.stall, m1_bus.stall, m0_bus.ack);
            end
        end
        rst_i = 1'b0;
        step();
        vectors++;
        if (grant_o !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected 01", grant_o);
        end
        do_burst(0, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL single_read_m0: got acks=%0d m1_acks=%0d route_err=%0d, expected 8 0 0", a, o, r);
        end
        m0_bus.cyc = 1'b0;
        step();
        vectors++;
        if (grant_o !== 2'b00 || out_bus.cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: got grant=%b cyc=%b, expected 00 0", grant_o, out_bus.cyc);
        end
    endtask

    task automatic test_contention(input int first, input string tag);
        int a, o, r;
        int second;
        second = 1 - first;
        set_req(0, 1'b0, 32'h0000_1000 + AW'($urandom_range(0, 255)) * 16, '0, 4'hF);
        set_req(1, 1'b0, 32'h0040_0000 + AW'($urandom_range(0, 255)) * 16, '0, 4'hF);
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
        step();
        vectors++;
        if (grant_o !== gvec(first) || grant_o !== model_vec()) begin
            miscompares++;
            $display("FAIL %s_first: got %b expected %b", tag, grant_o, gvec(first));
        end
        do_burst(first, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL %s_burst1: got acks=%0d other=%0d err=%0d, expected 8 0 0", tag, a, o, r);
        end
        set_cyc(first, 1'b0);
        step();
        vectors++;
        if (grant_o !== 2'b00 || out_bus.cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_gap: got grant=%b cyc=%b, expected 00 0", tag, grant_o, out_bus.cyc);
        end
        step();
        vectors++;
        if (grant_o !== gvec(second)) begin
            miscompares++;
            $display("FAIL %s_second: got %b expected %b", tag, grant_o, gvec(second));
        end
        do_burst(second, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL %s_burst2: got acks=%0d other=%0d err=%0d, expected 8 0 0", tag, a, o, r);
        end
        set_cyc(second, 1'b0);
        step();
    endtask

    task automatic test_contention_after_m0();
        int a, o, r;
        set_req(0, 1'b0, 32'h0000_2000, '0, 4'hF);
        m0_bus.cyc = 1'b1;
        step();
        do_burst(0, a, o, r);
        vectors++;
        if (a !== 8 || grant_o !== 2'b01) begin
            miscompares++;
            $display("FAIL prime_m0: got acks=%0d grant=%b, expected 8 01", a, grant_o);
        end
        m0_bus.cyc = 1'b0;
        repeat (2) step();
`ifdef SDRAM_ARB_RR_EN
        test_contention(1, "contention2");
`else
        test_contention(0, "contention2");
`endif
    endtask

    task automatic test_write_burst();
        int a, o, r;
        set_req(1, 1'b1, 32'h0080_0000, 32'hDEAD_BEEF, 4'hF);
        m1_bus.cyc = 1'b1;
        m1_bus.stb = 1'b1;
        step();
        vectors++;
        if (grant_o !== 2'b10) begin
            miscompares++;
            $display("FAIL write_grant: got %b expected 10", grant_o);
        end
        vectors++;
        if (out_bus.adr !== 32'h0080_0000 || out_bus.dat_i !== 32'hDEAD_BEEF ||
            out_bus.sel !== 4'hF || out_bus.we !== 1'b1) begin
            miscompares++;
            $display("FAIL write_passthru: got adr=%h dat=%h sel=%h we=%b, expected 00800000 deadbeef f 1",
                     out_bus.adr, out_bus.dat_i, out_bus.sel, out_bus.we);
        end
        vectors++;
        if (m0_bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL write_m0_stall: got %b expected 1", m0_bus.stall);
        end
        do_burst(1, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL write_burst: got acks=%0d m0_acks=%0d err=%0d, expected 8 0 0", a, o, r);
        end
        vectors++;
        if (wr_adr !== 32'h0080_0000 || wr_dat !== 32'hDEAD_BEEF || wr_sel !== 4'hF || wr_we !== 1'b1) begin
            miscompares++;
            $display("FAIL write_at_slave: got adr=%h dat=%h sel=%h we=%b, expected 00800000 deadbeef f 1",
                     wr_adr, wr_dat, wr_sel, wr_we);
        end
        m1_bus.cyc = 1'b0;
        m1_bus.we  = 1'b0;
        step();
    endtask

    task automatic test_handover();
        int a, o, r;
        set_req(0, 1'b0, 32'h0001_0000, '0, 4'hF);
        set_req(1, 1'b0, 32'h0002_0000, '0, 4'hF);
        m0_bus.cyc = 1'b1;
        step();
        do_burst(0, a, o, r);
        m0_bus.cyc = 1'b0;
        m1_bus.cyc = 1'b1;
        m1_bus.stb = 1'b1;
        step();
        vectors++;
        if (grant_o !== 2'b00 || out_bus.cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL handover_gap: got grant=%b cyc=%b, expected 00 0", grant_o, out_bus.cyc);
        end
        step();
        vectors++;
        if (grant_o !== 2'b10 || out_bus.cyc !== 1'b1) begin
            miscompares++;
            $display("FAIL handover_grant: got grant=%b cyc=%b, expected 10 1", grant_o, out_bus.cyc);
        end
        do_burst(1, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL handover_burst: got acks=%0d m0_acks=%0d err=%0d, expected 8 0 0", a, o, r);
        end
        m1_bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int   a, o, r, acks;
        logic accepted, take;
        acks     = 0;
        accepted = 1'b0;
        set_req(0, 1'b0, 32'h0003_0000, '0, 4'hF);
        m0_bus.cyc = 1'b1;
        m0_bus.stb = 1'b1;
        step();
        for (int n = 0; n < 30 && acks < 3; n++) begin
            take = !accepted && !m0_bus.stall;
            step();
            if (take) begin
                accepted   = 1'b1;
                m0_bus.stb = 1'b0;
            end
            if (m0_bus.ack === 1'b1) acks++;
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        vectors++;
        if (acks !== 3 || out_bus.cyc !== 1'b0 || grant_o !== 2'b00 || m0_bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: got acks=%0d cyc=%b grant=%b m0.stall=%b, expected 3 0 00 1",
                     acks, out_bus.cyc, grant_o, m0_bus.stall);
        end
        m0_bus.cyc = 1'b0;
        set_req(1, 1'b0, 32'h0050_0000, '0, 4'hF);
        m1_bus.cyc = 1'b1;
        step();
        vectors++;
        if (grant_o !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_regrant: got %b expected 10", grant_o);
        end
        do_burst(1, a, o, r);
        vectors++;
        if (a !== 8 || o !== 0 || r !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got acks=%0d m0_acks=%0d err=%0d, expected 8 0 0", a, o, r);
        end
        m1_bus.cyc = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        for (int i = 0; i < 400; i++) begin
            m0_bus.cyc   = m0_bus.cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            m1_bus.cyc   = m1_bus.cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            m0_bus.stb   = m0_bus.cyc && ($urandom_range(0, 1) == 1);
            m1_bus.stb   = m1_bus.cyc && ($urandom_range(0, 1) == 1);
            set_req(0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom_range(0, 15)));
            set_req(1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom_range(0, 15)));
            step();
            e_cyc = (exp_gnt == 1) ? m0_bus.cyc : (exp_gnt == 2) ? m1_bus.cyc : 1'b0;
            e_stb = (exp_gnt == 1) ? m0_bus.stb : (exp_gnt == 2) ? m1_bus.stb : 1'b0;
            e_we  = (exp_gnt == 1) ? m0_bus.we  : m1_bus.we;
            e_adr = (exp_gnt == 1) ? m0_bus.adr : m1_bus.adr;
            e_dat = (exp_gnt == 1) ? m0_bus.dat_i : m1_bus.dat_i;
            e_sel = (exp_gnt == 1) ? m0_bus.sel : m1_bus.sel;
            vectors++;
            if (grant_o !== model_vec()) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: got %b expected %b", i, grant_o, model_vec());
            end
            vectors++;
            if (out_bus.cyc !== e_cyc || out_bus.stb !== e_stb) begin
                miscompares++;
                $display("FAIL rand_cyc_stb[%0d]: got %b%b expected %b%b", i, out_bus.cyc, out_bus.stb, e_cyc, e_stb);
            end
            if (exp_gnt != 0) begin
                vectors++;
                if (out_bus.adr !== e_adr || out_bus.dat_i !== e_dat || out_bus.sel !== e_sel || out_bus.we !== e_we) begin
                    miscompares++;
                    $display("FAIL rand_fwd[%0d]: got adr=%h dat=%h expected adr=%h dat=%h",
                             i, out_bus.adr, out_bus.dat_i, e_adr, e_dat);
                end
            end
            vectors++;
            if (m0_bus.ack !== ((exp_gnt == 1) ? out_bus.ack : 1'b0) ||
                m0_bus.stall !== ((exp_gnt == 1) ? out_bus.stall : 1'b1) ||
                m0_bus.dat_o !== ((exp_gnt == 1) ? out_bus.dat_o : '0)) begin
                miscompares++;
                $display("FAIL rand_m0_ret[%0d]: got ack=%b stall=%b dat=%h with grant model %0d",
                         i, m0_bus.ack, m0_bus.stall, m0_bus.dat_o, exp_gnt);
            end
            vectors++;
            if (m1_bus.ack !== ((exp_gnt == 2) ? out_bus.ack : 1'b0) ||
                m1_bus.stall !== ((exp_gnt == 2) ? out_bus.stall : 1'b1) ||
                m1_bus.dat_o !== ((exp_gnt == 2) ? out_bus.dat_o : '0)) begin
                miscompares++;
                $display("FAIL rand_m1_ret[%0d]: got ack=%b stall=%b dat=%h with grant model %0d",
                         i, m1_bus.ack, m1_bus.stall, m1_bus.dat_o, exp_gnt);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
        m0_bus.adr = '0; m0_bus.sel = '0; m0_bus.dat_i = '0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
        m1_bus.adr = '0; m1_bus.sel = '0; m1_bus.dat_i = '0;

        test_reset();
        idle_masters();
        pulse_reset(2);
        idle_masters();
        test_contention(0, "contention1");
        idle_masters();
        test_contention_after_m0();
        idle_masters();
        test_write_burst();
        idle_masters();
        test_handover();
        idle_masters();
        test_reset_mid();
        idle_masters();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
